axi_mem_slave: RTL and testbench
================================

AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1024, memory size in 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-005 SHALL have port axi_awid  in  1  write transaction ID.
REQ-006 SHALL have port axi_awaddr  in  32  write burst start byte address.
REQ-007 SHALL have port axi_awlen  in  8  write beats minus one.
REQ-008 SHALL have port axi_awvalid  in  1  write address valid.
REQ-009 SHALL have port axi_awready  out  1  write address accepted.
REQ-010 SHALL have port axi_wdata  in  32  write data.
REQ-011 SHALL have port axi_wstrb  in  4  byte enables, bit n for wdata[8n+7:8n].
REQ-012 SHALL have port axi_wlast  in  1  master's last-beat marker.
REQ-013 SHALL have port axi_wvalid  in  1  write data valid.
REQ-014 SHALL have port axi_wready  out  1  write data accepted.
REQ-015 SHALL have port axi_bid  out  1  echoed awid.
REQ-016 SHALL have port axi_bresp  out  2  write response.
REQ-017 SHALL have port axi_bvalid  out  1  write response valid.
REQ-018 SHALL have port axi_bready  in  1  master accepts response.
REQ-019 SHALL have port axi_arid  in  1  read transaction ID.
REQ-020 SHALL have port axi_araddr  in  32  read burst start byte address.
REQ-021 SHALL have port axi_arlen  in  8  read beats minus one.
REQ-022 SHALL have port axi_arvalid  in  1  read address valid.
REQ-023 SHALL have port axi_arready  out  1  read address accepted.
REQ-024 SHALL have port axi_rid  out  1  echoed arid.
REQ-025 SHALL have port axi_rdata  out  32  read data.
REQ-026 SHALL have port axi_rresp  out  2  read response per beat.
REQ-027 SHALL have port axi_rlast  out  1  final read beat.
REQ-028 SHALL have port axi_rvalid  out  1  read data valid.
REQ-029 SHALL have port axi_rready  in  1  master accepts read beat.

Function
REQ-030 Write FSM SHALL be W_IDLE (awready=1) -> AW handshake latches awid/addr/awlen, beat count 0 -> W_DATA (wready=1) -> W_RESP (bvalid=1) -> W_IDLE on bready; no new AW accepted before B handshake.
REQ-031 Each W handshake SHALL write enabled bytes at word (addr-BASE_ADDR)>>2, then add 4 to addr; always 4-byte INCR, size/burst/lock/cache/prot/qos not ported.
REQ-032 Burst SHALL end on the beat where count==awlen regardless of wlast; bresp SHALL be 2'b10 (SLVERR) if wlast differed from (count==awlen) on any beat, else 2'b00.
REQ-033 Read FSM SHALL be R_IDLE (arready=1) -> AR handshake latches arid/addr/arlen -> R_DATA; rvalid SHALL assert the cycle after AR handshake with registered rdata of first word.
REQ-034 In R_DATA rvalid/rdata/rlast SHALL hold stable until rready; on handshake next word presents the following cycle with no bubble; rlast=1 only on beat arlen; after it -> R_IDLE, arready high next cycle.
REQ-035 Read and write FSMs SHALL run independently; same-cycle read fetch and write to one word SHALL return the pre-write value.
REQ-036 Address arithmetic SHALL be 32-bit, wrapping at 2^32; awlen=0 / arlen=0 single-beat bursts SHALL be supported.
REQ-037 bvalid and rvalid SHALL never depend combinationally on bready/rready.

Reset
REQ-038 While rst=0: all outputs 0, both FSMs idle, counters 0, memory contents untouched; awready/arready SHALL rise the first clk edge after rst=1; reset mid-burst SHALL abandon it without response.

Configuration
REQ-039 With AXI_SLV_DECERR_EN defined, beats whose word index >= MEM_DEPTH SHALL not write, SHALL read 32'h0, and SHALL give resp 2'b11 (DECERR, write response takes worst); undefined, word index SHALL wrap modulo MEM_DEPTH with OKAY.

Structure
REQ-040 AXI response codes (OKAY/SLVERR/DECERR) and FSM state enums SHALL live in shared package axi_pkg; byte-enabled storage SHALL be sub-module axi_slv_ram (one write port, one registered read port).

Verification
REQ-041 AW addr=0x10 len=3, four W beats 0xA0..0xA3 strb=4'hF, wlast on beat 3 -> bresp=00, bid=awid; read-back returns same values, rlast on beat 3.
REQ-042 Write 0xFFFFFFFF then strb=4'b0101 data 0x11223344 to 0x0 -> read 0xFF22FF44.
REQ-043 AW len=1, wlast asserted on beat 0 -> two beats still taken, bresp=2'b10.
REQ-044 AR len=2 with rready toggling 1,0,0,1,1 -> data stable while stalled, three beats exact, rlast only on third.
REQ-045 AR at word MEM_DEPTH -> DECERR and 0 with AXI_SLV_DECERR_EN; word 0 data, OKAY without.
REQ-046 rst=0 during beat 2 of a 4-beat write -> outputs 0 immediately; after release new single write completes with OKAY.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI response codes and the slave's read/write FSM state encodings.
package axi_pkg;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

endpackage

// File: rtl/axi_slv_ram.sv
// Word RAM with per-byte write enables, one write port and one registered read port.
// A read and write to the same word in one cycle returns the old contents.
module axi_slv_ram #(
  parameter int unsigned Depth = 1024,
  parameter int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  input  logic             re,
  input  logic [AddrW-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [Depth];

  // Storage is deliberately unreset so contents survive a bus reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 memory slave: independent INCR-only read and write burst engines over axi_slv_ram.
// Define AXI_SLV_DECERR_EN to answer DECERR beyond MEM_DEPTH instead of wrapping the index.
module axi_mem_slave
  import axi_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        axi_awid,
  input  logic [31:0] axi_awaddr,
  input  logic [7:0]  axi_awlen,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wlast,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic        axi_bid,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  input  logic        axi_arid,
  input  logic [31:0] axi_araddr,
  input  logic [7:0]  axi_arlen,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  output logic        axi_rid,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rlast,
  output logic        axi_rvalid,
  input  logic        axi_rready
);

  localparam int unsigned AddrW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  function automatic logic [31:0] word_idx(input logic [31:0] addr);
    return (addr - BASE_ADDR) >> 2;
  endfunction

  w_state_e    w_state_q, w_state_d;
  r_state_e    r_state_q, r_state_d;
  logic        alive_q;
  logic        aw_id_q, aw_id_d, ar_id_q, ar_id_d;
  logic [31:0] aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
  logic [7:0]  aw_len_q, aw_len_d, ar_len_q, ar_len_d;
  logic [7:0]  w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;
  logic        w_slverr_q, w_slverr_d, w_decerr_q, w_decerr_d;
  logic        r_oob_q, r_oob_d;

  logic        w_we, ram_re, w_beat_last, r_last, w_oob, r_oob;
  logic [31:0] w_idx, r_idx, r_fetch_addr, ram_rdata;

  // Next read word: the burst start while idle, else the word after the current beat.
  assign r_fetch_addr = (r_state_q == RIdle) ? axi_araddr : ar_addr_q + 32'd4;
  assign w_idx        = word_idx(aw_addr_q);
  assign r_idx        = word_idx(r_fetch_addr);
  assign w_beat_last  = (w_cnt_q == aw_len_q);
  assign r_last       = (r_state_q == RData) && (r_cnt_q == ar_len_q);

`ifdef AXI_SLV_DECERR_EN
  assign w_oob = (w_idx >= MEM_DEPTH);
  assign r_oob = (r_idx >= MEM_DEPTH);
`else
  assign w_oob = 1'b0;
  assign r_oob = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alive_q    <= 1'b0;
      w_state_q  <= WIdle;
      r_state_q  <= RIdle;
      aw_id_q    <= 1'b0;
      ar_id_q    <= 1'b0;
      aw_addr_q  <= '0;
      ar_addr_q  <= '0;
      aw_len_q   <= '0;
      ar_len_q   <= '0;
      w_cnt_q    <= '0;
      r_cnt_q    <= '0;
      w_slverr_q <= 1'b0;
      w_decerr_q <= 1'b0;
      r_oob_q    <= 1'b0;
    end else begin
      alive_q    <= 1'b1;
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      aw_id_q    <= aw_id_d;
      ar_id_q    <= ar_id_d;
      aw_addr_q  <= aw_addr_d;
      ar_addr_q  <= ar_addr_d;
      aw_len_q   <= aw_len_d;
      ar_len_q   <= ar_len_d;
      w_cnt_q    <= w_cnt_d;
      r_cnt_q    <= r_cnt_d;
      w_slverr_q <= w_slverr_d;
      w_decerr_q <= w_decerr_d;
      r_oob_q    <= r_oob_d;
    end
  end

  always_comb begin
    w_state_d  = w_state_q;
    aw_id_d    = aw_id_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    w_cnt_d    = w_cnt_q;
    w_slverr_d = w_slverr_q;
    w_decerr_d = w_decerr_q;
    w_we       = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        if (axi_awvalid && alive_q) begin
          aw_id_d    = axi_awid;
          aw_addr_d  = axi_awaddr;
          aw_len_d   = axi_awlen;
          w_cnt_d    = '0;
          w_slverr_d = 1'b0;
          w_decerr_d = 1'b0;
          w_state_d  = WData;
        end
      end
      WData: begin
        if (axi_wvalid) begin
          w_we      = !w_oob;
          aw_addr_d = aw_addr_q + 32'd4;
          w_cnt_d   = w_cnt_q + 8'd1;
          // The beat count, not wlast, ends the burst; a disagreeing wlast only flags SLVERR.
          if (axi_wlast != w_beat_last) w_slverr_d = 1'b1;
          if (w_oob) w_decerr_d = 1'b1;
          if (w_beat_last) w_state_d = WResp;
        end
      end
      WResp: begin
        if (axi_bready) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    ar_id_d   = ar_id_q;
    ar_addr_d = ar_addr_q;
    ar_len_d  = ar_len_q;
    r_cnt_d   = r_cnt_q;
    r_oob_d   = r_oob_q;
    ram_re    = 1'b0;
    unique case (r_state_q)
      RIdle: begin
        if (axi_arvalid && alive_q) begin
          ram_re    = 1'b1;
          ar_id_d   = axi_arid;
          ar_addr_d = axi_araddr;
          ar_len_d  = axi_arlen;
          r_cnt_d   = '0;
          r_state_d = RData;
        end
      end
      RData: begin
        if (axi_rready) begin
          if (r_last) begin
            r_state_d = RIdle;
          end else begin
            ram_re    = 1'b1;
            ar_addr_d = r_fetch_addr;
            r_cnt_d   = r_cnt_q + 8'd1;
          end
        end
      end
      default: r_state_d = RIdle;
    endcase
    if (ram_re) r_oob_d = r_oob;
  end

  axi_slv_ram #(
    .Depth (MEM_DEPTH),
    .AddrW (AddrW)
  ) u_ram (
    .clk   (clk),
    .we    (w_we),
    .waddr (AddrW'(w_idx % MEM_DEPTH)),
    .wdata (axi_wdata),
    .wstrb (axi_wstrb),
    .re    (ram_re),
    .raddr (AddrW'(r_idx % MEM_DEPTH)),
    .rdata (ram_rdata)
  );

  assign axi_awready = alive_q && (w_state_q == WIdle);
  assign axi_wready  = (w_state_q == WData);
  assign axi_bvalid  = (w_state_q == WResp);
  assign axi_bid     = aw_id_q;
  assign axi_bresp   = !axi_bvalid ? RespOkay :
                       w_decerr_q  ? RespDecerr :
                       w_slverr_q  ? RespSlverr : RespOkay;

  assign axi_arready = alive_q && (r_state_q == RIdle);
  assign axi_rvalid  = (r_state_q == RData);
  assign axi_rid     = ar_id_q;
  assign axi_rlast   = r_last;
  // RAM output is unreset, so mask it outside an active beat.
  assign axi_rdata   = (axi_rvalid && !r_oob_q) ? ram_rdata : 32'h0;
  assign axi_rresp   = (axi_rvalid && r_oob_q) ? RespDecerr : RespOkay;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Scoreboard bench for axi_mem_slave: expected B and R beats are queued from a reference
// memory when stimulus is driven and compared as the DUT responds.
module tb_axi_mem_slave;

  localparam int unsigned Depth  = 64;
  localparam logic [31:0] Base   = 32'h0000_0000;
  localparam int          Budget = 200;

  logic        clk, rst;
  logic        axi_awid, axi_awvalid, axi_awready;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wlast, axi_wvalid, axi_wready;
  logic        axi_bid, axi_bvalid, axi_bready;
  logic [1:0]  axi_bresp;
  logic        axi_arid, axi_arvalid, axi_arready;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic        axi_rid, axi_rlast, axi_rvalid, axi_rready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [Depth];
  logic [2:0]  exp_b[$];
  logic [31:0] exp_rdata[$];
  logic [1:0]  exp_rresp[$];
  logic        exp_rlast[$];

  axi_mem_slave #(
    .MEM_DEPTH (Depth),
    .BASE_ADDR (Base)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .axi_awid    (axi_awid),
    .axi_awaddr  (axi_awaddr),
    .axi_awlen   (axi_awlen),
    .axi_awvalid (axi_awvalid),
    .axi_awready (axi_awready),
    .axi_wdata   (axi_wdata),
    .axi_wstrb   (axi_wstrb),
    .axi_wlast   (axi_wlast),
    .axi_wvalid  (axi_wvalid),
    .axi_wready  (axi_wready),
    .axi_bid     (axi_bid),
    .axi_bresp   (axi_bresp),
    .axi_bvalid  (axi_bvalid),
    .axi_bready  (axi_bready),
    .axi_arid    (axi_arid),
    .axi_araddr  (axi_araddr),
    .axi_arlen   (axi_arlen),
    .axi_arvalid (axi_arvalid),
    .axi_arready (axi_arready),
    .axi_rid     (axi_rid),
    .axi_rdata   (axi_rdata),
    .axi_rresp   (axi_rresp),
    .axi_rlast   (axi_rlast),
    .axi_rvalid  (axi_rvalid),
    .axi_rready  (axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_idx(input logic [31:0] a);
    return (a - Base) >> 2;
  endfunction

  function automatic logic model_oob(input logic [31:0] a);
`ifdef AXI_SLV_DECERR_EN
    return model_idx(a) >= Depth;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (model_oob(a)) return 32'h0;
    return model_mem[model_idx(a) % Depth];
  endfunction

  task automatic model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    w = model_mem[model_idx(a) % Depth];
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    model_mem[model_idx(a) % Depth] = w;
  endtask

  task automatic aw_send(input logic id, input logic [31:0] addr, input logic [7:0] len);
    logic hs;
    int   n;
    axi_awid = id; axi_awaddr = addr; axi_awlen = len; axi_awvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk); hs = axi_awready;
      @(posedge clk); #1; n++;
    end while (!hs && n < Budget);
    axi_awvalid = 1'b0;
    if (!hs) check("aw_timeout", 32'(hs), 32'd1);
  endtask

  task automatic ar_send(input logic id, input logic [31:0] addr, input logic [7:0] len);
    logic hs;
    int   n;
    axi_arid = id; axi_araddr = addr; axi_arlen = len; axi_arvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk); hs = axi_arready;
      @(posedge clk); #1; n++;
    end while (!hs && n < Budget);
    axi_arvalid = 1'b0;
    if (!hs) check("ar_timeout", 32'(hs), 32'd1);
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    logic hs;
    int   n;
    axi_wdata = d; axi_wstrb = s; axi_wlast = l; axi_wvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk); hs = axi_wready;
      @(posedge clk); #1; n++;
    end while (!hs && n < Budget);
    axi_wvalid = 1'b0; axi_wlast = 1'b0;
    if (!hs) check("w_timeout", 32'(hs), 32'd1);
  endtask

  task automatic b_collect();
    logic       got;
    logic [2:0] e;
    int         n;
    axi_bready = 1'b1;
    n = 0;
    do begin
      @(negedge clk); got = axi_bvalid;
      if (got) begin
        e = exp_b.pop_front();
        check("bid", 32'(axi_bid), 32'(e[2]));
        check("bresp", 32'(axi_bresp), 32'(e[1:0]));
      end
      @(posedge clk); #1; n++;
    end while (!got && n < Budget);
    axi_bready = 1'b0;
    if (!got) check("b_timeout", 32'(got), 32'd1);
  endtask

  task automatic write_burst(input logic id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [31:0] d0, input logic [3:0] strb, input int wlast_at);
    logic        slv, dec;
    logic [31:0] a;
    slv = 1'b0; dec = 1'b0;
    aw_send(id, addr, len);
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + 32'(4 * i);
      w_beat(d0 + 32'(i), strb, i == wlast_at);
      if ((i == wlast_at) != (i == int'(len))) slv = 1'b1;
      if (model_oob(a)) dec = 1'b1;
      else model_wr(a, d0 + 32'(i), strb);
    end
    exp_b.push_back({id, dec ? 2'b11 : slv ? 2'b10 : 2'b00});
    b_collect();
  endtask

  // pat bit k is rready on the k-th cycle that rvalid is seen high.
  task automatic read_burst(input logic id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [31:0] pat);
    logic [31:0] a, held;
    logic        held_v;
    int          beats, k, n;
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + 32'(4 * i);
      exp_rdata.push_back(model_rd(a));
      exp_rresp.push_back(model_oob(a) ? 2'b11 : 2'b00);
      exp_rlast.push_back(i == int'(len));
    end
    ar_send(id, addr, len);
    beats = 0; k = 0; n = 0; held_v = 1'b0; held = '0;
    while (beats <= int'(len) && n < Budget) begin
      @(negedge clk);
      if (n == 0) check("rvalid_latency", 32'(axi_rvalid), 32'd1);
      axi_rready = 1'b0;
      if (axi_rvalid) begin
        if (held_v) check("r_stall_stable", axi_rdata, held);
        axi_rready = (k < 32) ? pat[k] : 1'b1;
        k++;
        if (axi_rready) begin
          check("rdata", axi_rdata, exp_rdata.pop_front());
          check("rresp", 32'(axi_rresp), 32'(exp_rresp.pop_front()));
          check("rlast", 32'(axi_rlast), 32'(exp_rlast.pop_front()));
          check("rid", 32'(axi_rid), 32'(id));
          beats++;
          held_v = 1'b0;
        end else begin
          held   = axi_rdata;
          held_v = 1'b1;
        end
      end
      @(posedge clk); #1; n++;
    end
    axi_rready = 1'b0;
    check("r_beats", 32'(beats), 32'(len) + 32'd1);
    @(negedge clk);
    check("r_done_rvalid", 32'(axi_rvalid), 32'd0);
    check("r_done_arready", 32'(axi_arready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, 32'(axi_awready), 32'd0);
    check({tag, "_wready"}, 32'(axi_wready), 32'd0);
    check({tag, "_bvalid"}, 32'(axi_bvalid), 32'd0);
    check({tag, "_bresp"}, 32'(axi_bresp), 32'd0);
    check({tag, "_arready"}, 32'(axi_arready), 32'd0);
    check({tag, "_rvalid"}, 32'(axi_rvalid), 32'd0);
    check({tag, "_rdata"}, axi_rdata, 32'd0);
    check({tag, "_rlast"}, 32'(axi_rlast), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    axi_awid = 0; axi_awaddr = '0; axi_awlen = '0; axi_awvalid = 0;
    axi_wdata = '0; axi_wstrb = '0; axi_wlast = 0; axi_wvalid = 0; axi_bready = 0;
    axi_arid = 0; axi_araddr = '0; axi_arlen = '0; axi_arvalid = 0; axi_rready = 0;

    repeat (3) @(posedge clk);
    #1 check_all_zero("rst");
    @(negedge clk); rst = 1'b1;
    #1 check("awready_before_edge", 32'(axi_awready), 32'd0);
    @(posedge clk); #1;
    check("awready_after_edge", 32'(axi_awready), 32'd1);
    check("arready_after_edge", 32'(axi_arready), 32'd1);

    // Four-beat burst with correct wlast, then read back.
    write_burst(1'b1, 32'h10, 8'd3, 32'hA0, 4'hF, 3);
    read_burst(1'b1, 32'h10, 8'd3, 32'hFFFF_FFFF);

    // Byte strobes merge into an existing word.
    write_burst(1'b0, 32'h0, 8'd0, 32'hFFFF_FFFF, 4'hF, 0);
    write_burst(1'b0, 32'h0, 8'd0, 32'h1122_3344, 4'b0101, 0);
    read_burst(1'b0, 32'h0, 8'd0, 32'hFFFF_FFFF);

    // Early wlast still takes both beats; missing wlast on a single beat also flags SLVERR.
    write_burst(1'b1, 32'h100, 8'd1, 32'h5500, 4'hF, 0);
    read_burst(1'b0, 32'h100, 8'd1, 32'hFFFF_FFFF);
    write_burst(1'b0, 32'h20, 8'd0, 32'h7777_0000, 4'hF, -1);

    // rready pattern 1,0,0,1,1 over a three-beat read.
    read_burst(1'b1, 32'h10, 8'd2, 32'b11001);

    // One word past the end: DECERR/zero or wrap to word 0.
    read_burst(1'b0, Base + 32'(Depth * 4), 8'd0, 32'hFFFF_FFFF);
    write_burst(1'b1, Base + 32'(Depth * 4) + 32'h8, 8'd0, 32'hBEEF_0002, 4'hF, 0);
    read_burst(1'b0, 32'h8, 8'd0, 32'hFFFF_FFFF);

    // Reset while beat 2 of a four-beat write is pending.
    aw_send(1'b1, 32'h40, 8'd3);
    w_beat(32'h1000, 4'hF, 1'b0); model_wr(32'h40, 32'h1000, 4'hF);
    w_beat(32'h1001, 4'hF, 1'b0); model_wr(32'h44, 32'h1001, 4'hF);
    axi_wdata = 32'h1002; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1 check_all_zero("midrst");
    axi_wvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_awready_back", 32'(axi_awready), 32'd1);
    write_burst(1'b1, 32'h48, 8'd0, 32'hCAFE_0001, 4'hF, 0);
    read_burst(1'b0, 32'h40, 8'd2, 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
